// File: rtl/mic4_pulse_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mic4_pulse_sequencer_if
// Function : Control/status bundle between software registers and the Mic4
//            pulse sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mic4_pulse_sequencer_if #(
    parameter int CNT_WIDTH = 16,
    parameter int REP_WIDTH = 16
);
    logic                 start;
    logic                 abort;
    logic [3:0]           step_en;
    logic [CNT_WIDTH-1:0] dly_grst;
    logic [CNT_WIDTH-1:0] dly_a;
    logic [CNT_WIDTH-1:0] dly_s;
    logic [CNT_WIDTH-1:0] dly_d;
    logic [REP_WIDTH-1:0] n_rep;
    logic                 pulse_grst;
    logic                 pulse_a;
    logic                 pulse_s;
    logic                 pulse_d;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [REP_WIDTH-1:0] rep_count;

    modport master (
        output start, abort, step_en, dly_grst, dly_a, dly_s, dly_d, n_rep,
        input  pulse_grst, pulse_a, pulse_s, pulse_d, busy, done, aborted, rep_count
    );

    modport slave (
        input  start, abort, step_en, dly_grst, dly_a, dly_s, dly_d, n_rep,
        output pulse_grst, pulse_a, pulse_s, pulse_d, busy, done, aborted, rep_count
    );
endinterface
`default_nettype wire

// File: rtl/mic4_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mic4_pulse_sequencer
// Function : Cycle-exact GRST / A / strobe / D request sequencer with
//            programmable gaps and iteration count.
// Revision : 1.0 - initial release
// ============================================================================
module mic4_pulse_sequencer #(
    parameter int CNT_WIDTH = 16,
    parameter int REP_WIDTH = 16
) (
    input  wire logic               clk_in,
    input  wire logic               rst_n,
    mic4_pulse_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_P_GRST = 4'd1,
        ST_W_GRST = 4'd2,
        ST_P_A    = 4'd3,
        ST_W_A    = 4'd4,
        ST_P_S    = 4'd5,
        ST_W_S    = 4'd6,
        ST_P_D    = 4'd7,
        ST_W_D    = 4'd8
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [REP_WIDTH-1:0] rep_q, rep_d;
    logic [REP_WIDTH-1:0] w_rep_inc;
    logic                 aborted_q, aborted_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 pulse_grst_q, pulse_a_q, pulse_s_q, pulse_d_q;
    logic                 pulse_grst_d, pulse_a_d, pulse_s_d, pulse_d_d;
    logic                 w_load;
    logic                 w_iter_end;
    logic [3:0]           w_en;

    // Shadow copies of the run configuration, captured on an accepted start
    logic [3:0]           en_q;
    logic [CNT_WIDTH-1:0] dg_q, da_q, ds_q, dd_q;
    logic [REP_WIDTH-1:0] nrep_q;

    assign w_rep_inc = rep_q + REP_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rep_d      = rep_q;
        aborted_d  = aborted_q;
        done_d     = 1'b0;
        w_load     = 1'b0;
        w_iter_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_load    = 1'b1;
                    rep_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = ST_P_GRST;
                end
            end
            ST_P_GRST: begin
                if (dg_q != '0) begin
                    state_d = ST_W_GRST;
                    cnt_d   = dg_q - CNT_WIDTH'(1);
                end else begin
                    state_d = ST_P_A;
                end
            end
            ST_W_GRST: begin
                if (cnt_q == '0) state_d = ST_P_A;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            ST_P_A: begin
                if (da_q != '0) begin
                    state_d = ST_W_A;
                    cnt_d   = da_q - CNT_WIDTH'(1);
                end else begin
                    state_d = ST_P_S;
                end
            end
            ST_W_A: begin
                if (cnt_q == '0) state_d = ST_P_S;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            ST_P_S: begin
                if (ds_q != '0) begin
                    state_d = ST_W_S;
                    cnt_d   = ds_q - CNT_WIDTH'(1);
                end else begin
                    state_d = ST_P_D;
                end
            end
            ST_W_S: begin
                if (cnt_q == '0) state_d = ST_P_D;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            ST_P_D: begin
                if (dd_q != '0) begin
                    state_d = ST_W_D;
                    cnt_d   = dd_q - CNT_WIDTH'(1);
                end else begin
                    w_iter_end = 1'b1;
                end
            end
            ST_W_D: begin
                if (cnt_q == '0) w_iter_end = 1'b1;
                else             cnt_d      = cnt_q - CNT_WIDTH'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // n_rep of zero never matches, so continuous runs simply wrap
        if (w_iter_end) begin
            rep_d = w_rep_inc;
            if (nrep_q != '0 && w_rep_inc == nrep_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_P_A;
            end
        end

        // Abort wins over everything, including a finishing iteration
        if (state_q != ST_IDLE && bus.abort) begin
            state_d   = ST_IDLE;
            cnt_d     = cnt_q;
            rep_d     = rep_q;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end
    end

    assign w_en         = w_load ? bus.step_en : en_q;
    assign pulse_grst_d = (state_d == ST_P_GRST) && w_en[0];
    assign pulse_a_d    = (state_d == ST_P_A)    && w_en[1];
    assign pulse_s_d    = (state_d == ST_P_S)    && w_en[2];
    assign pulse_d_d    = (state_d == ST_P_D)    && w_en[3];
    assign busy_d       = (state_d != ST_IDLE);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rep_q        <= '0;
            aborted_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            pulse_grst_q <= 1'b0;
            pulse_a_q    <= 1'b0;
            pulse_s_q    <= 1'b0;
            pulse_d_q    <= 1'b0;
            en_q         <= '0;
            dg_q         <= '0;
            da_q         <= '0;
            ds_q         <= '0;
            dd_q         <= '0;
            nrep_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rep_q        <= rep_d;
            aborted_q    <= aborted_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            pulse_grst_q <= pulse_grst_d;
            pulse_a_q    <= pulse_a_d;
            pulse_s_q    <= pulse_s_d;
            pulse_d_q    <= pulse_d_d;
            if (w_load) begin
                en_q   <= bus.step_en;
                dg_q   <= bus.dly_grst;
                da_q   <= bus.dly_a;
                ds_q   <= bus.dly_s;
                dd_q   <= bus.dly_d;
                nrep_q <= bus.n_rep;
            end
        end
    end

    assign bus.pulse_grst = pulse_grst_q;
    assign bus.pulse_a    = pulse_a_q;
    assign bus.pulse_s    = pulse_s_q;
    assign bus.pulse_d    = pulse_d_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.rep_count  = rep_q;

endmodule
`default_nettype wire

// File: doc/mic4_pulse_sequencer.md
Name: mic4_pulse_sequencer

Overview:
- Programmable single-clock FSM that sequences the Mic4 test pulses: global reset, then per iteration A-pulse, strobe and D-pulse, with programmable gaps between them.
- Sits in the clk_control (100 MHz) domain, ahead of the Mic4 control block.
- Drives its one-cycle pulse_grst / pulse_a / pulse_s / pulse_d request inputs, which that block stretches to chip-level widths.
- Replaces ad-hoc software pulse triggering with deterministic, cycle-exact timing.

Parameters:
- CNT_WIDTH, 16, width of each programmable delay.
- REP_WIDTH, 16, width of iteration count and iteration counter.

Ports:
- clk_in  input  1  control clock (clk_control domain, 100 MHz).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; honoured only in IDLE.
- abort  input  1  level/pulse; terminates a run.
- step_en  input  4  step enables: [0] grst, [1] a, [2] s, [3] d.
- dly_grst  input  CNT_WIDTH  gap cycles after the GRST pulse.
- dly_a  input  CNT_WIDTH  gap cycles after the A pulse.
- dly_s  input  CNT_WIDTH  gap cycles after the strobe pulse.
- dly_d  input  CNT_WIDTH  gap cycles after the D pulse (end of iteration).
- n_rep  input  REP_WIDTH  iterations per run; 0 = continuous until abort.
- pulse_grst  output  1  one-cycle request to the GRST stretcher.
- pulse_a  output  1  one-cycle request to the A-pulse stretcher.
- pulse_s  output  1  one-cycle request to the strobe stretcher.
- pulse_d  output  1  one-cycle request to the D-pulse stretcher.
- busy  output  1  run in progress.
- done  output  1  one-cycle end-of-run flag.
- aborted  output  1  qualifies done; run ended by abort; held until next start.
- rep_count  output  REP_WIDTH  completed iterations in the current or last run.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE and all outputs to 0. Shadow registers and counters are cleared.
- All outputs are registered. Each pulse output is high only in the cycle the FSM occupies the matching pulse state.
- States: IDLE, P_GRST, W_GRST, P_A, W_A, P_S, W_S, P_D, W_D.
- IDLE:
  - start=1 and abort=0 at edge t: latch step_en, all dly_*, and n_rep into shadow registers; clear rep_count; clear aborted.
  - State is P_GRST from t+1, with busy=1 from t+1.
  - Inputs are ignored mid-run; only the shadow copies are used.
- Pulse states last exactly 1 cycle. The pulse output is asserted only if the matching shadow step_en bit is 1; otherwise the state still takes 1 cycle with no pulse.
- Wait states:
  - Wait W_x lasts exactly dly_x cycles using a down-counter loaded on entry.
  - dly_x=0 skips the wait state; the next pulse state follows directly.
  - Pulse-to-next-pulse spacing is therefore dly_x+1 cycles.
- Order: P_GRST → W_GRST → P_A → W_A → P_S → W_S → P_D → W_D.
  - P_GRST occurs once per run.
  - Leaving W_D, or P_D when dly_d=0: rep_count increments.
  - If n_rep≠0 and the new rep_count equals n_rep, the run finishes. The FSM goes to IDLE, busy=0, and done=1 for one cycle in that same cycle.
  - Otherwise the FSM returns to P_A.
- Continuous mode (n_rep=0): loops until abort. rep_count wraps modulo 2^REP_WIDTH; the wrap does not end the run.
- Abort:
  - abort=1 sampled in any non-IDLE state: next cycle IDLE, busy=0, done=1, aborted=1.
  - No pulse output is asserted in that cycle.
  - rep_count holds its value; a partially completed iteration is not counted.
  - abort in IDLE has no effect. start and abort together in IDLE: no run starts and done stays 0.
- start while busy is ignored; no queuing.
- The block does not check that gaps exceed downstream stretch lengths (A 100, D 300, GRST 5, strobe 2 cycles). Software must program dly_* accordingly.
- Mid-run reset: immediate return to IDLE with all outputs 0, and no done.

Test Plan:
1. Reset, then start with step_en=4'hF, dly_grst=10, dly_a=3, dly_s=5, dly_d=7, n_rep=2.
   - pulse_grst at t+1, pulse_a at t+12, pulse_s at t+16, pulse_d at t+22.
   - Second pulse_a at t+30, pulse_s at t+34, pulse_d at t+40.
   - done=1 and busy=0 at t+48; rep_count=2; aborted=0.
2. All dly_*=0, n_rep=1, step_en=4'hF → pulses on four consecutive cycles t+1..t+4; done at t+5.
3. step_en=4'b1011 (strobe disabled), same delays as test 1 → pulse_s never asserts; all other timing identical to test 1.
4. n_rep=0, all dly_*=2 → pulse_d recurs every 9 cycles.
   - Abort after 3 pulse_d: all pulses stop next cycle; done=1, aborted=1, rep_count=3.
5. Change dly_a and n_rep while busy, and pulse start while busy → timing matches the latched values; no restart.
6. Drive rst_n low mid-W_A → outputs 0 immediately; no done.
   - After release, start runs normally with rep_count cleared.
